// File: rtl/eth_rx_link_supervisor.sv
// eth_rx_link_supervisor: QSFP0 10G receive link supervisor.
// Syncs PHY/GT status, debounces lock, drives GT RX datapath resets.
module eth_rx_link_supervisor #(
   parameter int LOCK_TIMEOUT_CYCLES = 12500000,
   parameter int DEBOUNCE_CYCLES     = 1250,
   parameter int RESET_PULSE_CYCLES  = 16
) (
   input  logic       clk_125mhz_int,
   input  logic       gt_tx_reset,
   input  logic       rx_block_lock,
   input  logic       rx_high_ber,
   input  logic       gt_reset_rx_done,
   input  logic       qsfp_modprsl,
   output logic       gt_reset_rx_datapath,
   output logic       link_up,
   output logic       link_down_event,
   output logic [7:0] retry_count,
   output logic [2:0] state
);

   localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [2:0] NO_MODULE = 3'd0;
   localparam logic [2:0] WAIT_DONE = 3'd1;
   localparam logic [2:0] WAIT_LOCK = 3'd2;
   localparam logic [2:0] LINK_UP   = 3'd3;
   localparam logic [2:0] RESET     = 3'd4;

   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] PULSE_LEN    = TW'(RESET_PULSE_CYCLES);
   localparam logic [TW-1:0] PULSE_LAST   = TW'(RESET_PULSE_CYCLES - 1);
   localparam logic [DW-1:0] DEB_LAST     = DW'(DEBOUNCE_CYCLES - 1);

   // bit order: {modprsl, done, high_ber, lock}; modprsl idles "absent"
   localparam logic [3:0] SYNC_RST = 4'b1000;

   logic [3:0]    meta_q;
   logic [3:0]    sync_q;
   logic          lock_s;
   logic          high_ber_s;
   logic          done_s;
   logic          modprsl_s;
   logic          good;
   logic          deb_cond;
   logic          deb_hit;
   logic          timeout;
   logic          pulse_done;
   logic [2:0]    state_nxt;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_nxt;
   logic [DW-1:0] deb;
   logic [DW-1:0] deb_nxt;

   assign lock_s     = sync_q[0];
   assign high_ber_s = sync_q[1];
   assign done_s     = sync_q[2];
   assign modprsl_s  = sync_q[3];

   assign good       = lock_s & ~high_ber_s;
   assign deb_cond   = ((state == WAIT_LOCK) && good) ||
                       ((state == LINK_UP) && !good);
   assign deb_hit    = deb_cond && (deb == DEB_LAST);
   assign timeout    = (timer == TIMEOUT_LAST);
   assign pulse_done = (timer >= PULSE_LAST);

   // Two-flop synchronisers for the asynchronous status inputs.
   always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
      if (gt_tx_reset) begin
         meta_q <= SYNC_RST;
         sync_q <= SYNC_RST;
      end else begin
         meta_q <= {qsfp_modprsl, gt_reset_rx_done,
                    rx_high_ber, rx_block_lock};
         sync_q <= meta_q;
      end
   end

   // Next-state decision; module removal overrides every other exit.
   always_comb begin
      state_nxt = state;
      case (state)
         NO_MODULE: if (!modprsl_s) state_nxt = WAIT_DONE;
         WAIT_DONE: if (done_s) state_nxt = WAIT_LOCK;
         WAIT_LOCK: begin
            if (deb_hit)      state_nxt = LINK_UP;
            else if (timeout) state_nxt = RESET;
         end
         LINK_UP:   if (deb_hit) state_nxt = RESET;
         RESET: begin
            if ((pulse_done && !done_s) || timeout)
               state_nxt = WAIT_DONE;
         end
         default:   state_nxt = NO_MODULE;
      endcase
      if (modprsl_s) state_nxt = NO_MODULE;
   end

   // Timer and debounce count restart on every state change.
   always_comb begin
      timer_nxt = '0;
      deb_nxt   = '0;
      if (state_nxt == state) begin
         if ((state == WAIT_LOCK) || (state == RESET))
            timer_nxt = timer + 1'b1;
         if (deb_cond)
            deb_nxt = deb + 1'b1;
      end
   end

   // State, counters and outputs, all registered together.
   always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
      if (gt_tx_reset) begin
         state                <= NO_MODULE;
         timer                <= '0;
         deb                  <= '0;
         link_up              <= 1'b0;
         gt_reset_rx_datapath <= 1'b0;
         link_down_event      <= 1'b0;
         retry_count          <= 8'd0;
      end else begin
         state           <= state_nxt;
         timer           <= timer_nxt;
         deb             <= deb_nxt;
         link_up         <= (state_nxt == LINK_UP);
         link_down_event <= (state == LINK_UP) &&
                            (state_nxt != LINK_UP);
         gt_reset_rx_datapath <= (state_nxt == RESET) &&
                                 (timer_nxt < PULSE_LEN);
         if ((state_nxt == RESET) && (state != RESET) &&
             (retry_count != 8'hFF))
            retry_count <= retry_count + 8'd1;
      end
   end

endmodule
